vga_pixel_fetch: RTL and testbench
==================================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter HDISP, default 640: active pixels per line.
REQ-002 Parameter VDISP, default 480: active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two, min 4: pixel FIFO entries.
REQ-004 Derived ADDR_W = $clog2(HDISP*VDISP), 19 for default parameters.
REQ-005 vga_CLK  in  1  pixel clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 blank  in  1  1 = active display pixel, from the VGA timing generator.
REQ-008 vs  in  1  vertical sync, active-low, from the VGA timing generator.
REQ-009 rd_req  out  1  memory read request.
REQ-010 rd_addr  out  ADDR_W  linear pixel address, valid while rd_req=1.
REQ-011 rd_ack  in  1  memory accepts the request; rd_data valid in the same cycle.
REQ-012 rd_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-013 vga_r, vga_g, vga_b  out  8 each  registered pixel colour.
REQ-014 underflow  out  1  sticky: FIFO empty during an active pixel in the current frame.

Function
REQ-015 Frame start SHALL be the cycle in which vs is sampled 0 after being sampled 1 (registered falling-edge detect).
REQ-016 At frame start: FIFO flushed (count=0), address counter=0, underflow cleared, FSM to FETCH.
REQ-017 FSM states: WAIT_VS, FETCH, DONE; WAIT_VS after reset.
REQ-018 WAIT_VS: rd_req=0; leave only on frame start, to FETCH.
REQ-019 FETCH: rd_req=1 whenever FIFO count < FIFO_DEPTH, otherwise 0.
REQ-020 One request outstanding at most; a request is complete on the cycle rd_req=1 and rd_ack=1.
REQ-021 rd_addr SHALL hold stable while rd_req=1 and rd_ack=0.
REQ-022 On rd_ack: rd_data pushed into the FIFO, address counter +1.
REQ-023 When the ack for address HDISP*VDISP-1 is received: FSM to DONE, rd_req=0 from the next cycle.
REQ-024 DONE: rd_req=0; leave only on frame start, to FETCH.
REQ-025 rd_ack while rd_req=0 SHALL be ignored: no push, no address change.
REQ-026 Pop: in every cycle with blank=1 and FIFO non-empty, one entry is popped.
REQ-027 Output latency: the colour popped in cycle N appears on vga_r/g/b in cycle N+1.
REQ-028 blank=0 in cycle N: vga_r/g/b = 0 in cycle N+1; no pop.
REQ-029 blank=1 with FIFO empty in cycle N: vga_r/g/b = 0 in cycle N+1; underflow=1 from N+1 until the next frame start or reset.
REQ-030 Push and pop in the same cycle: count unchanged; no overflow or underflow.
REQ-031 Push with count = FIFO_DEPTH SHALL be impossible by construction (REQ-019, REQ-020).
REQ-032 Count width $clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
REQ-033 Frame start coincident with rd_ack: data discarded, address = 0, FIFO empty after the edge.
REQ-034 Frame start coincident with blank=1: flush takes priority; no pop; output 0 next cycle.
REQ-035 Frame start in FETCH mid-frame: fetching restarts at address 0 (resynchronisation).

Reset
REQ-036 On rst=1 at a clock edge: FSM=WAIT_VS, rd_req=0, rd_addr=0, FIFO count=0, pointers=0, vga_r/g/b=0, underflow=0, vs-edge register=1.
REQ-037 Reset overrides all other events in the same cycle, including rd_ack and frame start.
REQ-038 After reset, no request is issued before the first frame start.

Verification
REQ-039 Reset, vs held 1 for 100 cycles -> rd_req=0, RGB=0, underflow=0 throughout.
REQ-040 vs 1->0, memory acks every cycle with data=address, blank=0 -> 16 requests acked at addr 0..15, then rd_req=0 while FIFO full.
REQ-041 FIFO full, blank=1 for 640 cycles, ack latency 0 -> RGB sequence = 0,1,2,...,639 each one cycle after its blank cycle; underflow stays 0.
REQ-042 Memory acks only every 3rd cycle, blank=1 continuously -> FIFO drains, black pixels output, underflow=1 until next vs falling edge, then 0.
REQ-043 Full frame with HDISP=4, VDISP=2 -> exactly 8 acks (addr 0..7), FSM enters DONE, rd_req=0 until next frame start, then addr restarts at 0.
REQ-044 rst asserted mid-frame with rd_req=1 and rd_ack=1 in the same cycle -> no push, all outputs at reset values next cycle.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Streams one frame of 24-bit pixels from memory into a small FIFO and
//   hands them to the VGA colour outputs, one pixel per active display cycle.
//   Fetching starts on each falling edge of vs. It stops after the last pixel
//   of the frame has been acknowledged.
//
// Ports
//   vga_CLK    in   pixel clock; all logic uses its rising edge
//   rst        in   synchronous, active-high reset
//   blank      in   1 = active display pixel
//   vs         in   vertical sync, active-low
//   rd_req     out  memory read request
//   rd_addr    out  linear pixel address, valid while rd_req=1
//   rd_ack     in   memory accepts the request; rd_data is valid in the same cycle
//   rd_data    in   pixel {R,G,B}
//   vga_r/g/b  out  registered pixel colour
//   underflow  out  sticky flag: the FIFO was empty during an active pixel this frame
module vga_pixel_fetch #(
  parameter int HDISP      = 640,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W    = $clog2(HDISP*VDISP)
) (
  input  logic              vga_CLK,
  input  logic              rst,
  input  logic              blank,
  input  logic              vs,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [23:0]       rd_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HDISP*VDISP - 1);

  typedef enum logic [1:0] {WAIT_VS, FETCH, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_vsPrev;
  logic [ADDR_W-1:0] r_addr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [23:0]       r_mem [FIFO_DEPTH];
  logic [23:0]       r_rgb;
  logic              r_underflow;

  logic              w_frameStart;
  logic              w_rdReq;
  logic              w_push;
  logic              w_pop;

  // Frame start is a registered falling edge of vs. A frame start flushes the
  // FIFO, so any push or pop that coincides with it is suppressed.
  assign w_frameStart = r_vsPrev & ~vs;
  assign w_push       = w_rdReq & rd_ack & ~w_frameStart;
  assign w_pop        = blank & (r_count != '0) & ~w_frameStart;

  assign rd_req    = w_rdReq;
  assign rd_addr   = r_addr;
  assign vga_r     = r_rgb[23:16];
  assign vga_g     = r_rgb[15:8];
  assign vga_b     = r_rgb[7:0];
  assign underflow = r_underflow;

  // FSM state register
  always_ff @(posedge vga_CLK) begin
    if (rst) r_state <= WAIT_VS;
    else     r_state <= w_nextState;
  end

  // Next state and request generation. Requests are issued only while there
  // is room in the FIFO, so a push can never overflow it.
  always_comb begin
    w_nextState = r_state;
    w_rdReq     = 1'b0;
    case (r_state)
      WAIT_VS: begin
        if (w_frameStart) w_nextState = FETCH;
      end
      FETCH: begin
        w_rdReq = (r_count < FULL_CNT);
        if (!w_frameStart && w_rdReq && rd_ack && (r_addr == LAST_ADDR))
          w_nextState = DONE;
      end
      DONE: begin
        if (w_frameStart) w_nextState = FETCH;
      end
      default: w_nextState = WAIT_VS;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates all reads
  always_ff @(posedge vga_CLK) begin
    if (w_push) r_mem[r_wrPtr] <= rd_data;
  end

  // Address counter, FIFO pointers and count, colour output and underflow.
  // Frame start resynchronises everything to address 0 with an empty FIFO.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      r_vsPrev    <= 1'b1;
      r_addr      <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vsPrev <= vs;
      if (w_frameStart) begin
        r_addr      <= '0;
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_count     <= '0;
        r_rgb       <= '0;
        r_underflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_wrPtr <= r_wrPtr + 1'b1;
          r_addr  <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        end
        if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        r_rgb <= w_pop ? r_mem[r_rdPtr] : 24'd0;
        if (blank && (r_count == '0)) r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch
//   Bench for vga_pixel_fetch with a small 16x4 frame, so that one complete
//   frame, the DONE state and the restart at address 0 all fit in a short run.
//   A behavioural model predicts rd_req, rd_addr, underflow and the colour
//   stream. Each predicted colour is queued when its cycle is driven and is
//   compared one cycle later, when the DUT presents it.
module tb_vga_pixel_fetch;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(H*V);
  localparam int LAST  = H*V - 1;

  logic          vga_CLK = 1'b0;
  logic          rst;
  logic          blank;
  logic          vs;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [23:0]   rd_data;
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;
  logic          underflow;

  // Pixel clock
  always #5 vga_CLK = ~vga_CLK;

  vga_pixel_fetch #(.HDISP(H), .VDISP(V), .FIFO_DEPTH(DEPTH)) dut (
    .vga_CLK   (vga_CLK),
    .rst       (rst),
    .blank     (blank),
    .vs        (vs),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .underflow (underflow)
  );

  typedef enum int {M_WAIT, M_FETCH, M_DONE} mstate_t;

  int          checks = 0;
  int          errors = 0;
  bit          checkEn = 1'b0;
  mstate_t     mState = M_WAIT;
  int          mAddr = 0;
  bit          mVsPrev = 1'b1;
  bit          mUnder = 1'b0;
  logic [23:0] mFifo [$];
  logic [23:0] expQ [$];

  // The memory returns a pixel derived from its address, so that each
  // channel is distinct and a wrong address shows up in the colour stream.
  function automatic logic [23:0] pixOf(input int a);
    logic [5:0] x;
    x = a[5:0];
    return {2'b01, x, 2'b10, x, 2'b11, ~x};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Called #1 after a rising edge. The task checks the outputs settled from
  // that edge, drives the inputs for the next edge, advances the model across
  // that edge and then waits for it.
  task automatic applyStimulus(input bit rIn, input bit bIn, input bit vIn, input bit aIn);
    bit          mReq;
    bit          fs;
    bit          push;
    bit          pop;
    logic [23:0] e;
    mReq = (mState == M_FETCH) && (mFifo.size() < DEPTH);
    if (checkEn) begin
      checkOutput("rd_req", {31'd0, rd_req}, {31'd0, mReq});
      if (mReq) checkOutput("rd_addr", 32'(rd_addr), 32'(mAddr));
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, e});
      end
      checkOutput("underflow", {31'd0, underflow}, {31'd0, mUnder});
    end

    rst     = rIn;
    blank   = bIn;
    vs      = vIn;
    rd_ack  = aIn;
    rd_data = pixOf(int'(rd_addr));

    e  = 24'd0;
    fs = mVsPrev & ~vIn;
    if (rIn) begin
      mState  = M_WAIT;
      mAddr   = 0;
      mFifo.delete();
      mUnder  = 1'b0;
      mVsPrev = 1'b1;
    end else begin
      mVsPrev = vIn;
      if (fs) begin
        mFifo.delete();
        mAddr  = 0;
        mUnder = 1'b0;
        mState = M_FETCH;
      end else begin
        push = mReq & aIn;
        pop  = bIn && (mFifo.size() > 0);
        if (bIn && (mFifo.size() == 0)) mUnder = 1'b1;
        if (pop) e = mFifo.pop_front();
        if (push) begin
          mFifo.push_back(pixOf(mAddr));
          if (mAddr == LAST) begin
            mState = M_DONE;
            mAddr  = 0;
          end else begin
            mAddr++;
          end
        end
      end
    end
    expQ.push_back(e);
    @(posedge vga_CLK);
    #1;
  endtask

  initial begin
    // Reset; the first cycle only initialises, because the outputs are still unknown
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Idle with vs high: no requests; acks while idle must be ignored
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Frame start, then fill the FIFO with blank low until requests stop
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Active display with zero-latency memory: pushes and pops in the same cycle
    repeat (40) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5)  applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Memory stalls: the FIFO drains and underflow is raised
    repeat (35) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Finish the frame: requests stop at the last address (DONE)
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    // Frame start with blank high: flush wins, output black, underflow clears
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Slow memory: ack every third cycle while displaying
    for (int i = 0; i < 45; i++) applyStimulus(1'b0, 1'b1, 1'b1, (i % 3) == 0);

    // Frame start coinciding with an ack and an active pixel; the acked data is discarded
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Mid-frame resynchronisation restarts the address at 0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset while a request is being acknowledged; it must not be pushed
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
